// File: rtl/bitstream_eval_ctrl.sv
// rtl/bitstream_eval_ctrl.sv - stochastic sigmoid evaluation controller: LFSR bitstream out, ones count in
// Optional abort input enabled by defining EVAL_ABORT_EN.
module bitstream_eval_ctrl #(
   parameter int unsigned SETTLE = 16,
   parameter int unsigned LENGTH = 256,
   parameter logic [7:0]  SEED   = 8'hA5
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       start,
   input  logic [7:0] x_val,
`ifdef EVAL_ABORT_EN
   input  logic       abort,
`endif
   output logic       busy,
   output logic       done,
   output logic [7:0] result,
   output logic       dp_n_rst,
   output logic       dp_x,
   input  logic       dp_y
);

   localparam int unsigned MAX_CYC = (SETTLE > LENGTH) ? SETTLE : LENGTH;
   localparam int unsigned CW      = (MAX_CYC < 3) ? 1 : $clog2(MAX_CYC);
   localparam logic [CW-1:0] S_LAST = CW'((SETTLE == 0) ? 0 : SETTLE - 1);
   localparam logic [CW-1:0] L_LAST = CW'(LENGTH - 1);
   localparam logic [CW-1:0] C_LAST = CW'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_SETTLE,
      ST_COUNT,
      ST_DONE
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cyc, cyc_n;
   logic [8:0]    ones, ones_n;
   logic [7:0]    lfsr, lfsr_n, lfsr_step;
   logic [7:0]    x_q, x_n;
   logic [7:0]    result_n;
   logic          abort_hit;

`ifdef EVAL_ABORT_EN
   assign abort_hit = abort && (state != ST_IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   // Fibonacci taps 8,6,5,4: maximal length, the all-zero state is unreachable from SEED
   assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

   always_comb begin
      state_n  = state;
      cyc_n    = cyc;
      ones_n   = ones;
      lfsr_n   = lfsr;
      x_n      = x_q;
      result_n = result;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_n = ST_CLEAR;
               x_n     = x_val;
               cyc_n   = '0;
               ones_n  = '0;
            end
         end
         ST_CLEAR: begin
            lfsr_n = SEED;
            if (cyc == C_LAST) begin
               cyc_n   = '0;
               state_n = (SETTLE == 0) ? ST_COUNT : ST_SETTLE;
            end else begin
               cyc_n = cyc + CW'(1);
            end
         end
         ST_SETTLE: begin
            lfsr_n = lfsr_step;
            if (cyc == S_LAST) begin
               cyc_n   = '0;
               state_n = ST_COUNT;
            end else begin
               cyc_n = cyc + CW'(1);
            end
         end
         ST_COUNT: begin
            lfsr_n = lfsr_step;
            ones_n = ones + {8'd0, dp_y};
            if (cyc == L_LAST) begin
               cyc_n    = '0;
               state_n  = ST_DONE;
               result_n = ones_n[8] ? 8'hFF : ones_n[7:0];
            end else begin
               cyc_n = cyc + CW'(1);
            end
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
      if (abort_hit) begin
         state_n  = ST_IDLE;
         result_n = result;
      end
   end

   // Outputs are registered from next-state values so they line up with the state they describe
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state    <= ST_IDLE;
         cyc      <= '0;
         ones     <= '0;
         lfsr     <= SEED;
         x_q      <= '0;
         result   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         dp_n_rst <= 1'b0;
         dp_x     <= 1'b0;
      end else begin
         state    <= state_n;
         cyc      <= cyc_n;
         ones     <= ones_n;
         lfsr     <= lfsr_n;
         x_q      <= x_n;
         result   <= result_n;
         busy     <= (state_n != ST_IDLE);
         done     <= (state_n == ST_DONE);
         dp_n_rst <= (state_n == ST_SETTLE) || (state_n == ST_COUNT) || (state_n == ST_DONE);
         dp_x     <= ((state_n == ST_SETTLE) || (state_n == ST_COUNT)) && (lfsr_n < x_n);
      end
   end

endmodule

// File: tb/tb_bitstream_eval_ctrl.sv
// tb/tb_bitstream_eval_ctrl.sv - randomized self-checking bench for bitstream_eval_ctrl against a cycle-phase model
module tb_bitstream_eval_ctrl;

   localparam int         S    = 16;
   localparam int         L    = 256;
   localparam logic [7:0] SEED = 8'hA5;
   localparam int         T_DONE = 2 + S + L + 1;

   logic       clk = 1'b0;
   logic       n_rst, start, dp_y;
   logic [7:0] x_val;
   logic       busy, done, dp_n_rst, dp_x;
   logic [7:0] result;
`ifdef EVAL_ABORT_EN
   logic       abort;
`endif

   int         errors = 0;
   int         checks = 0;
   logic [7:0] seq [255];
   logic [7:0] last_result;

   always #5 clk = ~clk;

   bitstream_eval_ctrl #(.SETTLE(S), .LENGTH(L), .SEED(SEED)) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .start    (start),
      .x_val    (x_val),
`ifdef EVAL_ABORT_EN
      .abort    (abort),
`endif
      .busy     (busy),
      .done     (done),
      .result   (result),
      .dp_n_rst (dp_n_rst),
      .dp_x     (dp_x),
      .dp_y     (dp_y)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One evaluation: cycle n is the interval after the n-th edge following the start-sample edge
   task automatic run_eval(input logic [7:0] x, input int ymode, input int xs_cyc,
                           input int rst_cyc, input int ab_cyc);
      int         ones = 0;
      int         stop = 0;
      int         dones = 0;
      int         exp_dones;
      logic       b, d, r, px;
      logic [7:0] er;
      @(negedge clk);
      start = 1'b1;
      x_val = x;
`ifdef EVAL_ABORT_EN
      abort = (ab_cyc > 0);
`endif
      for (int n = 1; n <= T_DONE + 3; n++) begin
         @(negedge clk);
         b = 0; d = 0; r = 0; px = 0; er = last_result;
         if (stop == 0 || n <= stop) begin
            if (n <= 2) begin
               b = 1;
            end else if (n <= 2 + S + L) begin
               b = 1; r = 1;
               px = (seq[(n - 3) % 255] < x);
            end else if (n == T_DONE) begin
               b = 1; d = 1; r = 1;
               er = (ones > 255) ? 8'hFF : 8'(ones);
               last_result = er;
            end
         end
         if (done === 1'b1) dones++;
         chk($sformatf("cyc%0d x=%02h", n, x), {20'd0, busy, done, dp_n_rst, dp_x, result},
             {20'd0, b, d, r, px, er});
         start = (n == xs_cyc);
         n_rst = 1'b1;
         x_val = 8'($urandom);
`ifdef EVAL_ABORT_EN
         abort = 1'b0;
         if (n == ab_cyc) begin
            abort = 1'b1;
            stop  = n;
         end
`endif
         if (n == rst_cyc) begin
            n_rst = 1'b0;
            stop  = n;
            last_result = 8'd0;
         end
         case (ymode)
            0:       dp_y = 1'b0;
            1:       dp_y = 1'b1;
            2:       dp_y = (n >= 3 + S) ? ((n - 3 - S) % 2 == 0) : 1'b1;
            default: dp_y = 1'($urandom);
         endcase
         if (n >= 3 + S && n <= 2 + S + L && dp_y) ones++;
      end
      exp_dones = (stop == 0 || stop >= T_DONE) ? 1 : 0;
      chk("done_count", dones, exp_dones);
   endtask

   initial begin
      seq[0] = SEED;
      for (int i = 1; i < 255; i++)
         seq[i] = {seq[i-1][6:0], seq[i-1][7] ^ seq[i-1][5] ^ seq[i-1][4] ^ seq[i-1][3]};
      n_rst = 1'b0; start = 1'b1; dp_y = 1'b1; x_val = 8'h3C;
`ifdef EVAL_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("reset", {busy, done, dp_n_rst, dp_x, result}, 12'd0);
      start = 1'b0; n_rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("idle", {busy, done, dp_n_rst, dp_x, result}, 12'd0);
      last_result = 8'd0;

      run_eval(8'h80, 1, 0, 0, 0);
      run_eval(8'h80, 0, 0, 0, 0);
      run_eval(8'h55, 2, 0, 0, 0);
      run_eval(8'h00, 3, 0, 0, 0);
      run_eval(8'hFF, 3, 0, 0, 0);
      run_eval(8'($urandom), 3, 2 + S + 50, 0, 0);
      run_eval(8'($urandom), 3, T_DONE, 0, 0);
      run_eval(8'($urandom), 1, 0, 2 + S + 100, 0);
      run_eval(8'($urandom), 3, 0, 0, 0);
`ifdef EVAL_ABORT_EN
      run_eval(8'($urandom), 1, 0, 0, 10);
      run_eval(8'($urandom), 3, 0, 0, 0);
`endif
      for (int k = 0; k < 3; k++)
         run_eval(8'($urandom), 3, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
